// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encodings and the documented-6502
// opcode table giving {legal, length} for every opcode byte.
package fetch_pkg;

   typedef enum logic [2:0] {
      S_VEC_LO    = 3'd0,
      S_VEC_HI    = 3'd1,
      S_FETCH_OP  = 3'd2,
      S_FETCH_B1  = 3'd3,
      S_FETCH_B2  = 3'd4,
      S_ISSUE     = 3'd5,
      S_STEP_WAIT = 3'd6
   } fetch_state_t;

   typedef struct packed {
      logic       legal;
      logic [1:0] len;
   } op_info_t;

   // Undocumented opcodes fall through to length 1 so they still issue.
   function automatic op_info_t op_lookup(input logic [7:0] op);
      op_info_t r;
      case (op)
         8'h00, 8'h08, 8'h0A, 8'h18, 8'h28, 8'h2A, 8'h38, 8'h40, 8'h48, 8'h4A,
         8'h58, 8'h60, 8'h68, 8'h6A, 8'h78, 8'h88, 8'h8A, 8'h98, 8'h9A, 8'hA8,
         8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA, 8'hF8:
            r = '{legal: 1'b1, len: 2'd1};
         8'h09, 8'h29, 8'h49, 8'h69, 8'hA0, 8'hA2, 8'hA9, 8'hC0, 8'hC9, 8'hE0,
         8'hE9,
         8'h05, 8'h06, 8'h24, 8'h25, 8'h26, 8'h45, 8'h46, 8'h65, 8'h66, 8'h84,
         8'h85, 8'h86, 8'hA4, 8'hA5, 8'hA6, 8'hC4, 8'hC5, 8'hC6, 8'hE4, 8'hE5,
         8'hE6,
         8'h15, 8'h16, 8'h35, 8'h36, 8'h55, 8'h56, 8'h75, 8'h76, 8'h94, 8'h95,
         8'hB4, 8'hB5, 8'hD5, 8'hD6, 8'hF5, 8'hF6, 8'h96, 8'hB6,
         8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1,
         8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1,
         8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
            r = '{legal: 1'b1, len: 2'd2};
         8'h0D, 8'h0E, 8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h4C, 8'h4D, 8'h4E, 8'h6D,
         8'h6E, 8'h8C, 8'h8D, 8'h8E, 8'hAC, 8'hAD, 8'hAE, 8'hCC, 8'hCD, 8'hCE,
         8'hEC, 8'hED, 8'hEE,
         8'h1D, 8'h1E, 8'h3D, 8'h3E, 8'h5D, 8'h5E, 8'h7D, 8'h7E, 8'h9D, 8'hBC,
         8'hBD, 8'hDD, 8'hDE, 8'hFD, 8'hFE,
         8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hBE, 8'hD9, 8'hF9, 8'h6C:
            r = '{legal: 1'b1, len: 2'd3};
         default:
            r = '{legal: 1'b0, len: 2'd1};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/opcode_length_decoder.sv
// Combinational opcode classifier: instruction length and documented flag.
module opcode_length_decoder
   import fetch_pkg::*;
(
   input  logic [7:0] i_opcode,
   output logic       o_legal,
   output logic [1:0] o_length
);

   op_info_t w_info;

   assign w_info   = op_lookup(i_opcode);
   assign o_legal  = w_info.legal;
   assign o_length = w_info.len;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, gathers opcode plus operand bytes
// from the ROM and hands whole instructions to execute over valid/ready.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int          USE_RESET_VECTOR = 0,
   parameter logic [15:0] RESET_VECTOR     = 16'hFFFC,
   parameter logic [15:0] START_ADDR       = 16'h0000
) (
   input  logic        clk_in,
   input  logic        reset,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data,
   input  logic        step_mode,
   input  logic        step_pulse,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [7:0]  instr_opcode,
   output logic [15:0] instr_operand,
   output logic [1:0]  instr_length,
   output logic [15:0] instr_pc,
   output logic        instr_illegal,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_addr,
   output logic [15:0] pc,
   output logic [2:0]  state_dbg
);

   localparam fetch_state_t RESET_STATE = (USE_RESET_VECTOR != 0) ? S_VEC_LO : S_FETCH_OP;

   fetch_state_t r_state;
   fetch_state_t w_next;
   logic [15:0]  r_pc;
   logic [7:0]   r_opcode;
   logic [15:0]  r_operand;
   logic [1:0]   r_len;
   logic [15:0]  r_pc_op;
   logic         r_illegal;
   logic         w_dec_legal;
   logic [1:0]   w_dec_len;
   logic         w_redir;

   opcode_length_decoder u_dec (
      .i_opcode (mem_data),
      .o_legal  (w_dec_legal),
      .o_length (w_dec_len)
   );

   // Vector fetch ignores redirects; everywhere else a redirect wins.
   assign w_redir = redirect_valid &&
                    (r_state inside {S_FETCH_OP, S_FETCH_B1, S_FETCH_B2, S_ISSUE, S_STEP_WAIT});

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) r_state <= RESET_STATE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_VEC_LO:    w_next = S_VEC_HI;
         S_VEC_HI:    w_next = S_FETCH_OP;
         S_FETCH_OP:  w_next = (w_dec_len == 2'd1) ? S_ISSUE : S_FETCH_B1;
         S_FETCH_B1:  w_next = (r_len == 2'd3) ? S_FETCH_B2 : S_ISSUE;
         S_FETCH_B2:  w_next = S_ISSUE;
         S_ISSUE:     if (instr_ready) w_next = step_mode ? S_STEP_WAIT : S_FETCH_OP;
         S_STEP_WAIT: if (step_pulse || !step_mode) w_next = S_FETCH_OP;
         default:     w_next = RESET_STATE;
      endcase
      if (w_redir) w_next = step_mode ? S_STEP_WAIT : S_FETCH_OP;
   end

   always_comb begin
      mem_rd   = 1'b0;
      mem_addr = r_pc;
      case (r_state)
         S_VEC_LO: begin
            mem_rd   = 1'b1;
            mem_addr = RESET_VECTOR;
         end
         S_VEC_HI: begin
            mem_rd   = 1'b1;
            mem_addr = RESET_VECTOR + 16'd1;
         end
         S_FETCH_OP, S_FETCH_B1, S_FETCH_B2: mem_rd = 1'b1;
         default: ;
      endcase
      // Bus is quiet while reset is held, even in the vector-fetch start state.
      if (reset) begin
         mem_rd   = 1'b0;
         mem_addr = 16'h0000;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_pc      <= START_ADDR;
         r_opcode  <= 8'h00;
         r_operand <= 16'h0000;
         r_len     <= 2'd0;
         r_pc_op   <= 16'h0000;
         r_illegal <= 1'b0;
      end else if (w_redir) begin
         r_pc <= redirect_addr;
      end else begin
         case (r_state)
            S_VEC_LO: r_pc[7:0]  <= mem_data;
            S_VEC_HI: r_pc[15:8] <= mem_data;
            S_FETCH_OP: begin
               r_opcode  <= mem_data;
               r_pc_op   <= r_pc;
               r_len     <= w_dec_len;
               r_illegal <= ~w_dec_legal;
               r_operand <= 16'h0000;
               r_pc      <= r_pc + 16'd1;
            end
            S_FETCH_B1: begin
               r_operand[7:0] <= mem_data;
               r_pc           <= r_pc + 16'd1;
            end
            S_FETCH_B2: begin
               r_operand[15:8] <= mem_data;
               r_pc            <= r_pc + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign instr_valid   = (r_state == S_ISSUE);
   assign instr_opcode  = r_opcode;
   assign instr_operand = r_operand;
   assign instr_length  = r_len;
   assign instr_pc      = r_pc_op;
   assign instr_illegal = r_illegal;
   assign pc            = r_pc;
   assign state_dbg     = r_state;

endmodule
